mem_bus_arbiter: RTL and testbench

- Sole owner of the single byte-wide system memory bus.
- Shares it between the instruction fetcher (word reads) and the memory operator (byte/half/word loads and stores dispatched by the central schedule unit).
- Sequences each access as a byte-serial FSM, reassembles read data little-endian, stalls stores to the IO region while the IO buffer is full, and aborts reads on pipeline flush.

---
 rtl/mem_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Byte-serial arbiter for the shared system memory bus: fetch and memory-operator ports.
// Build option MEM_ARB_ROUND_ROBIN_EN swaps fixed mo-first priority for round-robin on ties.
module mem_bus_arbiter #(
    parameter int          ADDR_W = 32,
    parameter logic [1:0]  IO_HI  = 2'b11
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_pipline,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              mo_req,
    input  logic              mo_we,
    input  logic [ADDR_W-1:0] mo_addr,
    input  logic [1:0]        mo_size,
    input  logic [31:0]       mo_wdata,
    output logic              mo_gnt,
    output logic              mo_done,
    output logic [31:0]       mo_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_size;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_owner_mo;
    logic              r_we;

    logic              w_arb_ok;
    logic              w_pick_mo;
    logic [1:0]        w_size_n;
    logic [2:0]        w_nbytes;
    logic              w_addr_phase;
    logic [ADDR_W-1:0] w_cur_a;
    logic [7:0]        w_wbyte;
    logic              w_io_stall;
    logic [1:0]        w_cap_idx;

    assign w_arb_ok = (r_state == S_IDLE) && rdy_in && !flush_pipline;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_mo;
    // On a tie the port that did not win last time goes first.
    assign w_pick_mo = mo_req && (!if_req || !r_last_mo);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_last_mo <= 1'b0;
        end else if (mo_gnt) begin
            r_last_mo <= 1'b1;
        end else if (if_gnt) begin
            r_last_mo <= 1'b0;
        end
    end
`else
    assign w_pick_mo = mo_req;
`endif

    assign mo_gnt = w_arb_ok && w_pick_mo;
    assign if_gnt = w_arb_ok && if_req && !w_pick_mo;

    assign w_size_n     = (mo_size == 2'd2) ? 2'd3 : mo_size;
    assign w_nbytes     = {1'b0, r_size} + 3'd1;
    assign w_addr_phase = (r_cnt <= {1'b0, r_size});
    assign w_cur_a      = r_base + {{(ADDR_W-2){1'b0}}, r_cnt[1:0]};
    assign w_wbyte      = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
    assign w_io_stall   = (w_cur_a[17:16] == IO_HI) && io_buffer_full;
    // Byte addressed in the previous cycle lands now; count 4 wraps to lane 3.
    assign w_cap_idx    = r_cnt[1:0] - 2'd1;

    always_comb begin
        mem_a    = '0;
        mem_dout = 8'h00;
        mem_wr   = 1'b0;
        if ((r_state == S_RD && w_addr_phase) || r_state == S_WR) begin
            mem_a = w_cur_a;
        end
        if (r_state == S_WR) begin
            mem_dout = w_wbyte;
            mem_wr   = rdy_in && !w_io_stall;
        end
    end

    // Reads abandoned by a flush in DONE never report; stores always do.
    assign if_done  = (r_state == S_DONE) && !r_owner_mo && rdy_in && !flush_pipline;
    assign mo_done  = (r_state == S_DONE) && r_owner_mo && rdy_in && (r_we || !flush_pipline);
    assign if_rdata = if_done ? r_rdata : 32'h0;
    assign mo_rdata = mo_done ? r_rdata : 32'h0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_base     <= '0;
            r_size     <= 2'd0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_owner_mo <= 1'b0;
            r_we       <= 1'b0;
        end else if (rdy_in) begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 3'd0;
                    if (mo_gnt) begin
                        r_owner_mo <= 1'b1;
                        r_we       <= mo_we;
                        r_base     <= mo_addr;
                        r_size     <= w_size_n;
                        r_wdata    <= mo_wdata;
                        r_rdata    <= 32'h0;
                        r_state    <= mo_we ? S_WR : S_RD;
                    end else if (if_gnt) begin
                        r_owner_mo <= 1'b0;
                        r_we       <= 1'b0;
                        r_base     <= if_addr;
                        r_size     <= 2'd3;
                        r_wdata    <= 32'h0;
                        r_rdata    <= 32'h0;
                        r_state    <= S_RD;
                    end
                end
                S_RD: begin
                    if (flush_pipline) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 3'd0;
                        r_rdata <= 32'h0;
                    end else begin
                        if (r_cnt != 3'd0) begin
                            r_rdata[{w_cap_idx, 3'b000} +: 8] <= mem_din;
                        end
                        if (r_cnt == w_nbytes) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                S_WR: begin
                    if (!w_io_stall) begin
                        if (r_cnt[1:0] == r_size) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector table plus reset and contention sequences.
module tb_mem_bus_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush_pipline = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_gnt, if_done;
    logic [31:0] if_rdata;
    logic        mo_req = 1'b0;
    logic        mo_we = 1'b0;
    logic [31:0] mo_addr = 32'h0;
    logic [1:0]  mo_size = 2'd0;
    logic [31:0] mo_wdata = 32'h0;
    logic        mo_gnt, mo_done;
    logic [31:0] mo_rdata;
    logic [7:0]  mem_din = 8'h0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    mem_bus_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
        .mo_req(mo_req), .mo_we(mo_we), .mo_addr(mo_addr), .mo_size(mo_size), .mo_wdata(mo_wdata),
        .mo_gnt(mo_gnt), .mo_done(mo_done), .mo_rdata(mo_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        fl, rdy, ir;
        logic [31:0] ia;
        logic        mr, mw;
        logic [31:0] ma;
        logic [1:0]  ms;
        logic [31:0] md;
        logic [7:0]  din;
        logic        iof;
        logic        e_ig, e_mg, e_id, e_md;
        logic [31:0] e_a;
        logic        e_wr;
        logic [7:0]  e_do;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vec_q[$];

    task automatic add(input logic fl, rdy, ir, input logic [31:0] ia, input logic mr, mw,
                       input logic [31:0] ma, input logic [1:0] ms, input logic [31:0] md,
                       input logic [7:0] din, input logic iof, input logic e_ig, e_mg, e_id, e_md,
                       input logic [31:0] e_a, input logic e_wr, input logic [7:0] e_do,
                       input logic [31:0] e_rd);
        vec_t v;
        v.fl = fl; v.rdy = rdy; v.ir = ir; v.ia = ia; v.mr = mr; v.mw = mw; v.ma = ma;
        v.ms = ms; v.md = md; v.din = din; v.iof = iof; v.e_ig = e_ig; v.e_mg = e_mg;
        v.e_id = e_id; v.e_md = e_md; v.e_a = e_a; v.e_wr = e_wr; v.e_do = e_do; v.e_rd = e_rd;
        vec_q.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk_in);
        flush_pipline = v.fl; rdy_in = v.rdy; if_req = v.ir; if_addr = v.ia;
        mo_req = v.mr; mo_we = v.mw; mo_addr = v.ma; mo_size = v.ms; mo_wdata = v.md;
        mem_din = v.din; io_buffer_full = v.iof;
        #1;
        n_vec++;
        chk($sformatf("v%0d if_gnt", idx), if_gnt, v.e_ig);
        chk($sformatf("v%0d mo_gnt", idx), mo_gnt, v.e_mg);
        chk($sformatf("v%0d if_done", idx), if_done, v.e_id);
        chk($sformatf("v%0d mo_done", idx), mo_done, v.e_md);
        chk($sformatf("v%0d mem_a", idx), mem_a, v.e_a);
        chk($sformatf("v%0d mem_wr", idx), mem_wr, v.e_wr);
        chk($sformatf("v%0d mem_dout", idx), mem_dout, v.e_do);
        chk($sformatf("v%0d if_rdata", idx), if_rdata, v.e_id ? v.e_rd : 32'h0);
        chk($sformatf("v%0d mo_rdata", idx), mo_rdata, v.e_md ? v.e_rd : 32'h0);
    endtask

    task automatic drop_all();
        flush_pipline = 1'b0; rdy_in = 1'b1; if_req = 1'b0; mo_req = 1'b0;
        mo_we = 1'b0; mem_din = 8'h0; io_buffer_full = 1'b0;
    endtask

    initial begin
        logic order [3];
        logic exp_order [3];
        int   ng;

        // Instruction fetch of four bytes from 0x100
        add(0,1,1,'h100,0,0,0,0,0,'h00,0, 1,0,0,0,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h100,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h13,0, 0,0,0,0,'h101,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h05,0, 0,0,0,0,'h102,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h10,0, 0,0,0,0,'h103,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,1,0,'h0,0,'h00,'h00100513);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h0,0,'h00,0);
        // Half-word load from 0x2002
        add(0,1,0,0,1,0,'h2002,1,0,'h00,0, 0,1,0,0,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h2002,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'hFF,0, 0,0,0,0,'h2003,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h80,0, 0,0,0,0,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,1,'h0,0,'h00,'h000080FF);
        // IO byte store held off by a full IO buffer
        add(0,1,0,0,1,1,'h30000,0,'h41,'h00,0, 0,1,0,0,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,1, 0,0,0,0,'h30000,0,'h41,0);
        add(0,1,0,0,0,0,0,0,0,'h00,1, 0,0,0,0,'h30000,0,'h41,0);
        add(0,1,0,0,0,0,0,0,0,'h00,1, 0,0,0,0,'h30000,0,'h41,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h30000,1,'h41,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,1,'h0,0,'h00,0);
        // Store outside the IO region ignores io_buffer_full
        add(0,1,0,0,1,1,'h20000,0,'h99,'h00,1, 0,1,0,0,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,1, 0,0,0,0,'h20000,1,'h99,0);
        add(0,1,0,0,0,0,0,0,0,'h00,1, 0,0,0,1,'h0,0,'h00,0);
        // Size code 2 acts as a word; address wraps past 0xFFFFFFFF
        add(0,1,0,0,1,1,'hFFFFFFFE,2,'hA1B2C3D4,'h00,0, 0,1,0,0,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'hFFFFFFFE,1,'hD4,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'hFFFFFFFF,1,'hC3,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h0,1,'hB2,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h1,1,'hA1,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,1,'h0,0,'h00,0);
        // Contention: mo first, fetch after mo_done, then flushed mid-read
        add(0,1,1,'h200,1,1,'h40,0,'h5A,'h00,0, 0,1,0,0,'h0,0,'h00,0);
        add(0,1,1,'h200,0,0,0,0,0,'h00,0, 0,0,0,0,'h40,1,'h5A,0);
        add(0,1,1,'h200,0,0,0,0,0,'h00,0, 0,0,0,1,'h0,0,'h00,0);
        add(0,1,1,'h200,0,0,0,0,0,'h00,0, 1,0,0,0,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h200,0,'h00,0);
        add(1,1,0,0,0,0,0,0,0,'h77,0, 0,0,0,0,'h201,0,'h00,0);
        add(0,1,1,'h300,0,0,0,0,0,'h00,0, 1,0,0,0,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h300,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'hAA,0, 0,0,0,0,'h301,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'hBB,0, 0,0,0,0,'h302,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'hCC,0, 0,0,0,0,'h303,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'hDD,0, 0,0,0,0,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,1,0,'h0,0,'h00,'hDDCCBBAA);
        // No grant during flush or while rdy_in is low
        add(1,1,1,'h500,1,0,'h10,0,0,'h00,0, 0,0,0,0,'h0,0,'h00,0);
        add(0,0,1,'h500,1,0,'h10,0,0,'h00,0, 0,0,0,0,'h0,0,'h00,0);
        // Byte load frozen for one cycle by rdy_in
        add(0,1,0,0,1,0,'h10,0,0,'h00,0, 0,1,0,0,'h0,0,'h00,0);
        add(0,0,0,0,0,0,0,0,0,'h55,0, 0,0,0,0,'h10,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h10,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h7E,0, 0,0,0,0,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,1,'h0,0,'h00,'h0000007E);
        // Byte store frozen by rdy_in: write strobe suppressed, then re-driven
        add(0,1,0,0,1,1,'h50,0,'h33,'h00,0, 0,1,0,0,'h0,0,'h00,0);
        add(0,0,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h50,0,'h33,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h50,1,'h33,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,1,'h0,0,'h00,0);
        // Flush during DONE suppresses a load's done pulse
        add(0,1,0,0,1,0,'h60,0,0,'h00,0, 0,1,0,0,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h60,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h11,0, 0,0,0,0,'h0,0,'h00,0);
        add(1,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h0,0,'h00,0);
        // Flush during WR and DONE leaves a store untouched
        add(0,1,0,0,1,1,'h70,0,'h22,'h00,0, 0,1,0,0,'h0,0,'h00,0);
        add(1,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h70,1,'h22,0);
        add(1,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,1,'h0,0,'h00,0);
        add(0,1,0,0,0,0,0,0,0,'h00,0, 0,0,0,0,'h0,0,'h00,0);

        // Reset state
        #2;
        n_vec++;
        chk("rst mem_a", mem_a, 32'h0);
        chk("rst mem_wr", mem_wr, 1'b0);
        chk("rst mem_dout", mem_dout, 8'h0);
        chk("rst if_done", if_done, 1'b0);
        chk("rst mo_done", mo_done, 1'b0);
        chk("rst if_rdata", if_rdata, 32'h0);
        chk("rst mo_rdata", mo_rdata, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;

        foreach (vec_q[i]) apply(vec_q[i], i);

        // Asynchronous reset in the middle of a word store
        @(negedge clk_in);
        drop_all();
        mo_req = 1'b1; mo_we = 1'b1; mo_addr = 32'h500; mo_size = 2'd3; mo_wdata = 32'h01020304;
        #1;
        n_vec++;
        chk("ar mo_gnt", mo_gnt, 1'b1);
        @(negedge clk_in);
        mo_req = 1'b0;
        #1;
        n_vec++;
        chk("ar mem_wr before", mem_wr, 1'b1);
        chk("ar mem_a before", mem_a, 32'h500);
        chk("ar mem_dout before", mem_dout, 8'h04);
        #1 rst_in = 1'b1;
        #1;
        n_vec++;
        chk("ar mem_wr", mem_wr, 1'b0);
        chk("ar mem_a", mem_a, 32'h0);
        chk("ar mem_dout", mem_dout, 8'h0);
        chk("ar mo_done", mo_done, 1'b0);
        #1 rst_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            #1;
            n_vec++;
            chk($sformatf("ar idle%0d mo_done", c), mo_done, 1'b0);
            chk($sformatf("ar idle%0d mem_wr", c), mem_wr, 1'b0);
            chk($sformatf("ar idle%0d mem_a", c), mem_a, 32'h0);
        end
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h600;
        #1;
        n_vec++;
        chk("ar if_gnt", if_gnt, 1'b1);
        @(negedge clk_in);
        if_req = 1'b0;
        #1;
        n_vec++;
        chk("ar fetch mem_a", mem_a, 32'h600);
        repeat (8) @(negedge clk_in);

        // Both requests held continuously: order of the first three grants
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1;
`else
        exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1;
`endif
        order[0] = 1'b0; order[1] = 1'b0; order[2] = 1'b0;
        ng = 0;
        @(negedge clk_in);
        if_req = 1'b1; if_addr = 32'h400;
        mo_req = 1'b1; mo_we = 1'b1; mo_addr = 32'h80; mo_size = 2'd0; mo_wdata = 32'h11;
        for (int c = 0; c < 40 && ng < 3; c++) begin
            #1;
            if (mo_gnt) begin
                order[ng] = 1'b1;
                ng++;
            end else if (if_gnt) begin
                order[ng] = 1'b0;
                ng++;
            end
            @(negedge clk_in);
        end
        drop_all();
        n_vec++;
        chk("tie grant count", ng, 3);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            chk($sformatf("tie grant%0d is_mo", k), order[k], exp_order[k]);
        end
        repeat (10) @(negedge clk_in);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
